// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: EX-stage operand forwarding selects and load-use stall control for the 5-stage core.
// Optional stall/forward event counters are compiled in when FWD_HAZARD_STATS_EN is defined.
module fwd_hazard_ctrl #(
  parameter int LOAD_USE_BUBBLES = 1,
  parameter int REG_AW           = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  input  logic              flush_i,
  output logic [1:0]        forward_a_o,
  output logic [1:0]        forward_b_o,
  output logic              pc_write_o,
  output logic              ifid_write_o,
  output logic              bubble_o
`ifdef FWD_HAZARD_STATS_EN
  ,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       fwd_cnt_o
`endif
);

  // Flow control: id_valid_i qualifies the ID fields in the cycle it is high; pc_write_o and
  // ifid_write_o are level enables for the same cycle, and bubble_o marks that the ID/EX
  // register takes a bubble at the next edge instead of the ID instruction.

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  typedef struct packed {
    state_t     state;
    logic [1:0] cnt;
  } fsm_t;

  localparam logic [1:0] CNT_INIT = (LOAD_USE_BUBBLES > 1) ? 2'(LOAD_USE_BUBBLES - 2) : 2'd0;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_WB  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;

  fsm_t              fsm_q;

  logic [REG_AW-1:0] ex_rs1;
  logic [REG_AW-1:0] ex_rs2;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_regwrite;
  logic              ex_memread;
  logic [REG_AW-1:0] mem_rd;
  logic              mem_regwrite;
  logic [REG_AW-1:0] wb_rd;
  logic              wb_regwrite;

  logic              in_run;
  logic              hazard_raw;
  logic              hazard;
  logic              ex_load;
  logic              mem_fwd_ok;
  logic              wb_fwd_ok;

  assign in_run = (fsm_q.state == RUN);

  // A load in EX whose result the ID instruction needs cannot be forwarded in time.
  assign hazard_raw = id_valid_i && !flush_i && ex_memread && ex_regwrite &&
                      (ex_rd != '0) && ((ex_rd == id_rs1_i) || (ex_rd == id_rs2_i));
  assign hazard     = in_run && hazard_raw;

  always_comb begin
    pc_write_o   = 1'b1;
    ifid_write_o = 1'b1;
    bubble_o     = 1'b0;
    if (!in_run) begin
      bubble_o = 1'b1;
      if (!flush_i) begin
        pc_write_o   = 1'b0;
        ifid_write_o = 1'b0;
      end
    end else if (flush_i) begin
      bubble_o = 1'b1;
    end else if (hazard) begin
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
      bubble_o     = 1'b1;
    end
  end

  assign ex_load = id_valid_i && !bubble_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fsm_q.state <= RUN;
      fsm_q.cnt   <= 2'd0;
    end else if (fsm_q.state == RUN) begin
      if (hazard && (LOAD_USE_BUBBLES > 1)) begin
        fsm_q.state <= STALL;
        fsm_q.cnt   <= CNT_INIT;
      end
    end else begin
      if (flush_i || (fsm_q.cnt == 2'd0)) begin
        fsm_q.state <= RUN;
        fsm_q.cnt   <= 2'd0;
      end else begin
        fsm_q.cnt <= fsm_q.cnt - 2'd1;
      end
    end
  end

  // Bubbles carry zero source indices too, so an empty EX slot never asks for forwarding.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      ex_rd        <= '0;
      ex_regwrite  <= 1'b0;
      ex_memread   <= 1'b0;
      mem_rd       <= '0;
      mem_regwrite <= 1'b0;
      wb_rd        <= '0;
      wb_regwrite  <= 1'b0;
    end else begin
      wb_rd        <= mem_rd;
      wb_regwrite  <= mem_regwrite;
      mem_rd       <= ex_rd;
      mem_regwrite <= ex_regwrite;
      if (ex_load) begin
        ex_rs1      <= id_rs1_i;
        ex_rs2      <= id_rs2_i;
        ex_rd       <= id_rd_i;
        ex_regwrite <= id_regwrite_i;
        ex_memread  <= id_memread_i;
      end else begin
        ex_rs1      <= '0;
        ex_rs2      <= '0;
        ex_rd       <= '0;
        ex_regwrite <= 1'b0;
        ex_memread  <= 1'b0;
      end
    end
  end

  assign mem_fwd_ok = mem_regwrite && (mem_rd != '0);
  assign wb_fwd_ok  = wb_regwrite && (wb_rd != '0);

  always_comb begin
    forward_a_o = SEL_RF;
    if (mem_fwd_ok && (mem_rd == ex_rs1)) begin
      forward_a_o = SEL_MEM;
    end else if (wb_fwd_ok && (wb_rd == ex_rs1)) begin
      forward_a_o = SEL_WB;
    end
  end

  always_comb begin
    forward_b_o = SEL_RF;
    if (mem_fwd_ok && (mem_rd == ex_rs2)) begin
      forward_b_o = SEL_MEM;
    end else if (wb_fwd_ok && (wb_rd == ex_rs2)) begin
      forward_b_o = SEL_WB;
    end
  end

`ifdef FWD_HAZARD_STATS_EN
  logic fwd_active;

  assign fwd_active = (forward_a_o != SEL_RF) || (forward_b_o != SEL_RF);

  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_o <= 32'd0;
      fwd_cnt_o   <= 32'd0;
    end else begin
      if (!pc_write_o && (stall_cnt_o != 32'hFFFF_FFFF)) begin
        stall_cnt_o <= stall_cnt_o + 32'd1;
      end
      if (fwd_active && (fwd_cnt_o != 32'hFFFF_FFFF)) begin
        fwd_cnt_o <= fwd_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule
